// File: rtl/dpsk_pkg.sv
// Shared constants, state type and width helpers for the DPSK modem.
// The modulator's build-time constants live here alongside the demodulator's.
package dpsk_pkg;

  localparam int unsigned VcoPrecise    = 12;
  localparam int unsigned Fs            = 48000;
  localparam int unsigned Fb            = 1200;
  localparam int unsigned FrameTotalLen = 64;

  localparam int unsigned ProdW = 2 * VcoPrecise;
  localparam int unsigned AccW  = ProdW + $clog2(Fs / Fb);

  typedef enum logic [1:0] {
    StIdle,
    StRef,
    StRun
  } demod_state_t;

  function automatic int unsigned prod_width(int unsigned w);
    return 2 * w;
  endfunction

  // Product sum of spb terms fits without overflow, including (-2^(w-1))^2 * spb.
  function automatic int unsigned acc_width(int unsigned w, int unsigned spb);
    return 2 * w + $clog2(spb);
  endfunction

  // Width of a counter that holds 0 .. n-1.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Magnitude in wider arithmetic so the most negative sample is representable.
  function automatic logic [31:0] magnitude(logic signed [31:0] x);
    return (x < 0) ? -x : x;
  endfunction

endpackage

// File: rtl/dpsk_demod_if.sv
// Sample-in / bit-out signal bundle of the DPSK demodulator.
interface dpsk_demod_if #(
  parameter int unsigned W = 8
);
  logic signed [W-1:0] adc_demod_data;
  logic                adc_demod_valid;
  logic                demod_data;
  logic                demod_valid;
  logic                demod_last;
  logic                demod_busy;

  modport master (
    output adc_demod_data,
    output adc_demod_valid,
    input  demod_data,
    input  demod_valid,
    input  demod_last,
    input  demod_busy
  );

  modport slave (
    input  adc_demod_data,
    input  adc_demod_valid,
    output demod_data,
    output demod_valid,
    output demod_last,
    output demod_busy
  );
endinterface

// File: rtl/dpsk_delay_line.sv
// SPB-deep circular sample buffer; read and write share one address, so the read
// returns the sample written SPB writes ago.
module dpsk_delay_line
  import dpsk_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned SPB = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic signed [W-1:0] wdata,
  output logic signed [W-1:0] rdata
);

  localparam int unsigned PtrW = cnt_width(SPB);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(SPB - 1);

  logic signed [W-1:0] mem [SPB];
  logic [PtrW-1:0]     ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (we) begin
      ptr_q <= (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);
    end
  end

  // Contents are not reset; the reference bit always refills them before use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr_q] <= wdata;
    end
  end

  assign rdata = mem[ptr_q];

endmodule

// File: rtl/dpsk_demod.sv
// DPSK burst demodulator: carrier detect, delay-and-multiply, integrate-and-dump
// over each bit, and sign slicing of the integrated product.
module dpsk_demod
  import dpsk_pkg::*;
#(
  parameter int unsigned W         = VcoPrecise,
  parameter int unsigned SPB       = Fs / Fb,
  parameter int unsigned FRAME_LEN = FrameTotalLen,
  parameter int unsigned THRESH    = 2 ** (W - 2)
) (
  input logic         sys_clk,
  input logic         rst,
  dpsk_demod_if.slave bus
);

  localparam int unsigned PW  = prod_width(W);
  localparam int unsigned AW  = acc_width(W, SPB);
  localparam int unsigned ScW = cnt_width(SPB);
  localparam int unsigned BcW = cnt_width(FRAME_LEN);
  localparam logic [ScW-1:0] SampleLast = ScW'(SPB - 1);
  localparam logic [BcW-1:0] BitLast    = BcW'(FRAME_LEN - 2);

  demod_state_t         state_q, state_d;
  logic [ScW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BcW-1:0]       bit_cnt_q, bit_cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;

  logic signed [W-1:0]  x;
  logic signed [W-1:0]  x_dly;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic                 detect;
  logic                 dl_we;

  assign x       = bus.adc_demod_data;
  assign prod    = PW'(x) * PW'(x_dly);
  assign acc_sum = acc_q + AW'(prod);
  assign detect  = magnitude(32'(x)) >= 32'(THRESH);

  dpsk_delay_line #(
    .W   (W),
    .SPB (SPB)
  ) u_delay_line (
    .clk   (sys_clk),
    .rst   (rst),
    .we    (dl_we),
    .wdata (x),
    .rdata (x_dly)
  );

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    acc_d        = acc_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    last_d       = 1'b0;
    dl_we        = 1'b0;

    if (bus.adc_demod_valid) begin
      unique case (state_q)
        StIdle: begin
          if (detect) begin
            dl_we        = 1'b1;
            sample_cnt_d = ScW'(1);
            bit_cnt_d    = '0;
            state_d      = StRef;
          end
        end
        StRef: begin
          dl_we = 1'b1;
          if (sample_cnt_q == SampleLast) begin
            sample_cnt_d = '0;
            acc_d        = '0;
            state_d      = StRun;
          end else begin
            sample_cnt_d = sample_cnt_q + ScW'(1);
          end
        end
        StRun: begin
          dl_we = 1'b1;
          if (sample_cnt_q == SampleLast) begin
            // Negative correlation means a phase inversion, i.e. data bit 1.
            sample_cnt_d = '0;
            data_d       = acc_sum[AW-1];
            valid_d      = 1'b1;
            acc_d        = '0;
            bit_cnt_d    = bit_cnt_q + BcW'(1);
            if (bit_cnt_q == BitLast) begin
              last_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            acc_d        = acc_sum;
            sample_cnt_d = sample_cnt_q + ScW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      acc_q        <= '0;
      data_q       <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      acc_q        <= acc_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

  assign bus.demod_data  = data_q;
  assign bus.demod_valid = valid_q;
  assign bus.demod_last  = last_q;
  assign bus.demod_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_dpsk_demod.sv
// Randomised and directed bench for dpsk_demod; expected strobes come from an
// array-level correlation model over the recorded sample stream.
module tb_dpsk_demod;

  localparam int W      = 8;
  localparam int SPB    = 4;
  localparam int FL     = 8;
  localparam int THRESH = 32;

  typedef struct {
    logic d;
    logic l;
    logic b;
    int   c;
  } strobe_t;

  logic sys_clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  logic busy_seen = 1'b0;

  strobe_t obs_q[$];
  strobe_t exp_q[$];
  int      smp_q[$];
  int      acc_q[$];

  dpsk_demod_if #(.W(W)) bus ();

  dpsk_demod #(
    .W         (W),
    .SPB       (SPB),
    .FRAME_LEN (FL),
    .THRESH    (THRESH)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (bus.demod_busy === 1'b1) busy_seen = 1'b1;
    if (!rst && bus.demod_valid === 1'b1)
      obs_q.push_back('{d: bus.demod_data, l: bus.demod_last, b: bus.demod_busy, c: cyc});
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mag(int x);
    return (x < 0) ? -x : x;
  endfunction

  // For each carrier detect, bit k (1..FL-1) correlates its SPB samples with the
  // previous bit's; the strobe is due in the cycle after its last sample is taken.
  function automatic void model();
    int i = 0;
    bit stop = 1'b0;
    exp_q.delete();
    while (i < smp_q.size() && !stop) begin
      if (mag(smp_q[i]) < THRESH) begin
        i++;
      end else begin
        for (int k = 1; k < FL && !stop; k++) begin
          int base = i + k * SPB;
          int sum = 0;
          if (base + SPB - 1 >= smp_q.size()) begin
            stop = 1'b1;
          end else begin
            for (int j = 0; j < SPB; j++) sum += smp_q[base + j] * smp_q[base + j - SPB];
            exp_q.push_back('{d: (sum < 0), l: (k == FL - 1), b: (k != FL - 1),
                              c: acc_q[base + SPB - 1]});
          end
        end
        i += FL * SPB;
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      bus.adc_demod_valid = 1'b0;
    end
  endtask

  task automatic drive_sample(input int x);
    @(negedge sys_clk);
    bus.adc_demod_data  = 8'(x);
    bus.adc_demod_valid = 1'b1;
    smp_q.push_back(x);
    acc_q.push_back(cyc + 1);
  endtask

  // One burst of FL bits; flat chips fill the whole bit with the extreme value.
  task automatic add_burst(input int e[FL], input int amp, input int noise, input bit flat,
                           input int gap_lo, input int gap_hi, input int nsamp);
    int chip[SPB];
    int n = 0;
    for (int k = 0; k < FL; k++) begin
      int s = e[k] ? amp : -amp;
      if (flat) begin
        s = e[k] ? 127 : -128;
        chip = '{s, s, s, s};
      end else begin
        chip = '{s, 0, -s, 0};
      end
      for (int j = 0; j < SPB; j++) begin
        int x = chip[j];
        int g = $urandom_range(gap_hi, gap_lo);
        if (noise > 0) x += int'($urandom_range(2 * noise, 0)) - noise;
        x = (x > 127) ? 127 : ((x < -128) ? -128 : x);
        if (n < nsamp) begin
          drive_sample(x);
          if (g > 1) idle(g - 1);
        end
        n++;
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    idle(10);
    model();
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.data%0d", tag, i), obs_q[i].d, exp_q[i].d);
      check($sformatf("%s.last%0d", tag, i), obs_q[i].l, exp_q[i].l);
      check($sformatf("%s.busy%0d", tag, i), obs_q[i].b, exp_q[i].b);
      check($sformatf("%s.cyc%0d", tag, i), obs_q[i].c, exp_q[i].c);
    end
    check({tag, ".idle_busy"}, bus.demod_busy, 1'b0);
    obs_q.delete();
    smp_q.delete();
    acc_q.delete();
  endtask

  // Decoded bits against the hand-derived d_k = e_{k-1} ^ e_k of the pattern.
  task automatic check_bits(input string tag, input int d[FL-1]);
    for (int i = 0; i < FL - 1; i++)
      check($sformatf("%s.bit%0d", tag, i), (i < obs_q.size()) ? obs_q[i].d : 1'bx, d[i]);
  endtask

  initial begin
    int e[FL];
    rst = 1'b1;
    bus.adc_demod_valid = 1'b0;
    bus.adc_demod_data  = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check($sformatf("rst.valid%0d", i), bus.demod_valid, 1'b0);
      check($sformatf("rst.data%0d", i), bus.demod_data, 1'b0);
      check($sformatf("rst.last%0d", i), bus.demod_last, 1'b0);
      check($sformatf("rst.busy%0d", i), bus.demod_busy, 1'b0);
      bus.adc_demod_data  = (i % 2) ? -8'sd100 : 8'sd100;
      bus.adc_demod_valid = 1'b1;
    end
    @(negedge sys_clk);
    rst = 1'b0;
    bus.adc_demod_valid = 1'b0;
    idle(3);
    check("rst.busy_after", bus.demod_busy, 1'b0);
    check("rst.strobes", obs_q.size(), 0);

    add_burst('{1, 1, 1, 1, 1, 1, 1, 1}, 100, 0, 1'b0, 1, 1, 32);
    idle(10);
    check_bits("const", '{0, 0, 0, 0, 0, 0, 0});
    compare_stream("const");

    add_burst('{1, 0, 1, 0, 1, 0, 1, 0}, 100, 0, 1'b0, 1, 1, 32);
    idle(10);
    check_bits("alt", '{1, 1, 1, 1, 1, 1, 1});
    compare_stream("alt");

    add_burst('{1, 1, 0, 0, 1, 0, 0, 0}, 100, 0, 1'b0, 1, 1, 32);
    idle(10);
    check_bits("mixed", '{0, 1, 0, 1, 1, 0, 0});
    compare_stream("mixed");

    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) drive_sample((i % 4 == 0) ? 20 : ((i % 4 == 2) ? -20 : 0));
    idle(4);
    check("subthr.strobes", obs_q.size(), 0);
    check("subthr.busy", busy_seen, 1'b0);
    add_burst('{1, 1, 0, 0, 1, 0, 0, 0}, 100, 0, 1'b0, 1, 1, 32);
    idle(10);
    check_bits("subthr", '{0, 1, 0, 1, 1, 0, 0});
    compare_stream("subthr");

    add_burst('{1, 1, 0, 0, 1, 0, 0, 0}, 100, 0, 1'b0, 3, 3, 32);
    idle(10);
    check_bits("throttle", '{0, 1, 0, 1, 1, 0, 0});
    compare_stream("throttle");

    add_burst('{0, 1, 0, 1, 0, 1, 0, 1}, 0, 0, 1'b1, 1, 1, 32);
    idle(10);
    check_bits("extreme_inv", '{1, 1, 1, 1, 1, 1, 1});
    compare_stream("extreme_inv");

    add_burst('{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 1'b1, 1, 1, 32);
    idle(10);
    check_bits("extreme_const", '{0, 0, 0, 0, 0, 0, 0});
    compare_stream("extreme_const");

    // Reference bit plus three bits plus two samples, then reset mid-bit.
    add_burst('{1, 0, 0, 1, 1, 0, 1, 0}, 100, 0, 1'b0, 1, 1, 18);
    @(negedge sys_clk);
    rst = 1'b1;
    bus.adc_demod_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    compare_stream("midrst");
    add_burst('{1, 0, 0, 1, 1, 0, 1, 0}, 100, 0, 1'b0, 1, 1, 32);
    idle(10);
    check_bits("post_rst", '{1, 0, 1, 0, 1, 1, 1});
    compare_stream("post_rst");

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < FL; k++) e[k] = int'($urandom_range(1, 0));
      add_burst(e, int'($urandom_range(127, 50)), 8, 1'b0, 1, 3, 32);
      compare_stream($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
